sao_stat_ctb_accum: RTL

- Downstream of the per-4x4 SAO statistics block.
- Accepts one block's edge-offset statistics per handshake: per-category diff sum and sample count for EO categories 1..4.
- Accumulates them over one CTB, then drains the four category totals serially to the SAO offset/RD decision stage.

---
 rtl/sao_stat_ctb_accum.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sao_stat_ctb_accum.sv
// Accumulates per-4x4 SAO edge-offset statistics over one CTB, then drains the four
// category totals serially. Optional saturation/overflow flag under SAO_STAT_SAT_EN.
module sao_stat_ctb_accum #(
  parameter int unsigned diff_clip_bit = 4,
  parameter int unsigned blk_log2      = 8,
  parameter int unsigned ACC_W         = diff_clip_bit + 5 + blk_log2,
  parameter int unsigned CNT_W         = 5 + blk_log2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             blk_valid,
  output logic                             blk_ready,
  input  logic [4*(diff_clip_bit+5)-1:0]   blk_sum,
  input  logic [4*5-1:0]                   blk_num,
  input  logic                             blk_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [1:0]                       out_cat,
  output logic signed [ACC_W-1:0]          out_sum,
  output logic [CNT_W-1:0]                 out_num,
  output logic                             busy,
  output logic                             done,
  output logic                             ovf
);

  localparam int unsigned SUM_W = diff_clip_bit + 5;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_sum_q [4];
  logic signed [ACC_W-1:0] acc_sum_d [4];
  logic [CNT_W-1:0]        acc_num_q [4];
  logic [CNT_W-1:0]        acc_num_d [4];
  logic signed [ACC_W-1:0] blk_ext   [4];
  logic                    out_valid_q, out_valid_d;
  logic [1:0]              out_cat_q, out_cat_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      blk_ext[k] = {{(ACC_W-SUM_W){blk_sum[k*SUM_W+SUM_W-1]}}, blk_sum[k*SUM_W +: SUM_W]};
    end
  end

`ifdef SAO_STAT_SAT_EN
  logic signed [ACC_W:0] sum_wide [4];
  logic [3:0]            clamp;

  // One extra bit exposes overflow: top two bits disagree.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum_wide[k] = {acc_sum_q[k][ACC_W-1], acc_sum_q[k]} + {blk_ext[k][ACC_W-1], blk_ext[k]};
      clamp[k]    = sum_wide[k][ACC_W] != sum_wide[k][ACC_W-1];
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_cat_d   = out_cat_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    for (int k = 0; k < 4; k++) begin
      acc_sum_d[k] = acc_sum_q[k];
      acc_num_d[k] = acc_num_q[k];
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          ovf_d   = 1'b0;
          for (int k = 0; k < 4; k++) begin
            acc_sum_d[k] = '0;
            acc_num_d[k] = '0;
          end
        end
      end
      StAccum: begin
        if (blk_valid) begin
          for (int k = 0; k < 4; k++) begin
            acc_num_d[k] = acc_num_q[k] + CNT_W'(blk_num[k*5 +: 5]);
`ifdef SAO_STAT_SAT_EN
            if (clamp[k]) begin
              ovf_d        = 1'b1;
              acc_sum_d[k] = sum_wide[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
              acc_sum_d[k] = sum_wide[k][ACC_W-1:0];
            end
`else
            acc_sum_d[k] = acc_sum_q[k] + blk_ext[k];
`endif
          end
          if (blk_last) begin
            state_d     = StDrain;
            out_valid_d = 1'b1;
            out_cat_d   = 2'd0;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          out_cat_d = out_cat_q + 2'd1;
          if (out_cat_q == 2'd3) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_cat_q   <= 2'd0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        acc_sum_q[k] <= '0;
        acc_num_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_cat_q   <= out_cat_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      for (int k = 0; k < 4; k++) begin
        acc_sum_q[k] <= acc_sum_d[k];
        acc_num_q[k] <= acc_num_d[k];
      end
    end
  end

  assign blk_ready = (state_q == StAccum);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_cat   = out_cat_q;
  assign done      = done_q;
  // Accumulators are frozen in DRAIN, so the selected total is stable under backpressure.
  assign out_sum   = out_valid_q ? acc_sum_q[out_cat_q] : '0;
  assign out_num   = out_valid_q ? acc_num_q[out_cat_q] : '0;

`ifdef SAO_STAT_SAT_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
